// File: rtl/jtobj_dmascan_if.sv
`default_nettype none
// ============================================================================
// Module   : jtobj_dmascan_if
// Purpose  : Signal bundle of the object DMA engine: CPU RAM read port,
//            MMR controls/status and the scanner read port.
// Revision : 1.0 - initial release
// ============================================================================
interface jtobj_dmascan_if #(
  parameter int AW   = 13,
  parameter int OBJW = 8,
  parameter int WPOW = 3
);
  logic                 dma_en;
  logic                 bus8;
  logic                 dma_start;
  logic [AW-1:0]        ext_addr;
  logic [15:0]          ext_data;
  logic                 dma_bsy;
  logic                 dma_done;
  logic [OBJW:0]        obj_cnt;
  logic [OBJW+WPOW-1:0] scan_addr;
  logic [15:0]          scan_data;

  modport master (
    input  dma_en, bus8, dma_start, ext_data, scan_addr,
    output ext_addr, dma_bsy, dma_done, obj_cnt, scan_data
  );

  modport slave (
    output dma_en, bus8, dma_start, ext_data, scan_addr,
    input  ext_addr, dma_bsy, dma_done, obj_cnt, scan_data
  );
endinterface
`default_nettype wire

// File: rtl/jtobj_dmascan.sv
`default_nettype none
// ============================================================================
// Module   : jtobj_dmascan
// Purpose  : Object-table DMA for Konami-style sprite chips. Copies the CPU
//            object table into an internal table indexed by priority byte.
//            Define JTOBJ_DBLBUF_EN for a double-buffered (bank-swapped) table.
// Revision : 1.0 - initial release
// ============================================================================
module jtobj_dmascan #(
  parameter int OBJW  = 8,
  parameter int WPOW  = 3,
  parameter int SKIPW = 1,
  parameter int AW    = 13
)(
  input  wire logic       rst,
  input  wire logic       clk,
  input  wire logic       cen,
  jtobj_dmascan_if.master bus
);
  localparam int c_IW = OBJW + WPOW;
`ifdef JTOBJ_DBLBUF_EN
  localparam int c_BW = 1;
`else
  localparam int c_BW = 0;
`endif
  localparam int              c_TW     = c_IW + c_BW;
  localparam logic [WPOW-1:0] c_LASTW  = WPOW'(2**WPOW - 1 - SKIPW);
  localparam logic [OBJW-1:0] c_LASTO  = '1;
  localparam logic [c_IW-1:0] c_LASTI  = '1;
  localparam logic [OBJW:0]   c_CNTMAX = {1'b1, {OBJW{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_COPY, ST_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [15:0]     r_mem [0:(2**c_TW)-1];
  logic [c_IW-1:0] r_clr;
  logic            r_bus8, r_bank;
  // issue pointer, then tags for the address on the bus (a) and captured data (c)
  logic            r_ion, r_iph, r_a_v, r_a_ph, r_c_v, r_c_ph;
  logic [OBJW-1:0] r_iobj, r_a_obj, r_c_obj, r_dest;
  logic [WPOW-1:0] r_iw, r_a_w, r_c_w;
  logic [15:0]     r_c_data;
  logic [7:0]      r_hi;
  logic            r_acc;
  logic [OBJW:0]   r_cnt, r_obj_cnt;
  logic [AW-1:0]   r_ext_addr;

  logic            w_start, w_word_rdy, w_first, w_accept, w_reject, w_last;
  logic [15:0]     w_word;
  logic [OBJW:0]   w_cnt_nxt;
  logic            w_iss_on, w_iss_ph, w_adv_on, w_adv_ph;
  logic [OBJW-1:0] w_iss_obj, w_adv_obj;
  logic [WPOW-1:0] w_iss_w, w_adv_w;
  logic [c_IW-1:0] w_iss_widx, w_widx;
  logic [AW-1:0]   w_iss_addr;
  logic            w_we;
  logic [15:0]     w_wdata;
  logic [c_TW-1:0] w_waddr, w_raddr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    bus.dma_bsy  = 1'b0;
    bus.dma_done = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        bus.dma_bsy = 1'b1;
        if (cen && r_clr == c_LASTI) w_state_nxt = ST_COPY;
      end
      ST_COPY: begin
        bus.dma_bsy = 1'b1;
        if (cen && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.dma_done = 1'b1;
        if (cen) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // In 8-bit mode a word is complete once its second (even) byte is captured
  always_comb begin
    w_start    = cen && bus.dma_start && bus.dma_en && (r_state == ST_IDLE);
    w_word_rdy = r_c_v && (!r_bus8 || r_c_ph);
    w_word     = r_bus8 ? {r_hi, r_c_data[7:0]} : r_c_data;
    w_first    = w_word_rdy && (r_c_w == '0);
    w_accept   = w_first && w_word[15] && (w_word[7:0] != 8'd0);
    w_reject   = w_first && !w_accept;
    w_last     = w_word_rdy && (r_c_obj == c_LASTO) && (w_reject || r_c_w == c_LASTW);
    w_cnt_nxt  = (w_accept && r_cnt != c_CNTMAX) ? r_cnt + (OBJW+1)'(1) : r_cnt;

    w_iss_on  = r_ion;
    w_iss_obj = r_iobj;
    w_iss_w   = r_iw;
    w_iss_ph  = r_iph;
    if (w_reject) begin
      w_iss_on  = (r_c_obj != c_LASTO);
      w_iss_obj = r_c_obj + OBJW'(1);
      w_iss_w   = '0;
      w_iss_ph  = 1'b0;
    end
    w_iss_widx = {w_iss_obj, w_iss_w};
    w_iss_addr = r_bus8 ? AW'({w_iss_widx, ~w_iss_ph}) : AW'(w_iss_widx);

    w_adv_on  = w_iss_on;
    w_adv_obj = w_iss_obj;
    w_adv_w   = w_iss_w;
    w_adv_ph  = 1'b0;
    if (r_bus8 && !w_iss_ph) begin
      w_adv_ph = 1'b1;
    end else if (w_iss_w == c_LASTW) begin
      w_adv_w = '0;
      if (w_iss_obj == c_LASTO) w_adv_on  = 1'b0;
      else                      w_adv_obj = w_iss_obj + OBJW'(1);
    end else begin
      w_adv_w = w_iss_w + WPOW'(1);
    end

    w_we    = 1'b0;
    w_widx  = '0;
    w_wdata = '0;
    if (cen && r_state == ST_CLEAR) begin
      w_we   = 1'b1;
      w_widx = r_clr;
    end else if (cen && r_state == ST_COPY && w_word_rdy && (w_accept || (r_acc && r_c_w != '0))) begin
      w_we    = 1'b1;
      w_widx  = {(w_accept ? w_word[OBJW-1:0] : r_dest), r_c_w};
      w_wdata = w_word;
    end
  end

`ifdef JTOBJ_DBLBUF_EN
  assign w_waddr = {~r_bank, w_widx};
  assign w_raddr = {r_bank, bus.scan_addr};
`else
  assign w_waddr = w_widx;
  assign w_raddr = bus.scan_addr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr      <= '0;
      r_bus8     <= 1'b0;
      r_bank     <= 1'b0;
      r_ion      <= 1'b0;
      r_iph      <= 1'b0;
      r_iobj     <= '0;
      r_iw       <= '0;
      r_a_v      <= 1'b0;
      r_a_ph     <= 1'b0;
      r_a_obj    <= '0;
      r_a_w      <= '0;
      r_c_v      <= 1'b0;
      r_c_ph     <= 1'b0;
      r_c_obj    <= '0;
      r_c_w      <= '0;
      r_c_data   <= '0;
      r_hi       <= '0;
      r_acc      <= 1'b0;
      r_dest     <= '0;
      r_cnt      <= '0;
      r_obj_cnt  <= '0;
      r_ext_addr <= '0;
    end else if (cen) begin
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_clr      <= '0;
          r_bus8     <= bus.bus8;
          r_cnt      <= '0;
          r_ext_addr <= '0;
          r_acc      <= 1'b0;
          r_ion      <= 1'b1;
          r_iobj     <= '0;
          r_iw       <= '0;
          r_iph      <= 1'b0;
          r_a_v      <= 1'b0;
          r_c_v      <= 1'b0;
        end
        ST_CLEAR: r_clr <= r_clr + c_IW'(1);
        ST_COPY: begin
          if (w_iss_on) r_ext_addr <= w_iss_addr;
          r_a_v   <= w_iss_on;
          r_a_obj <= w_iss_obj;
          r_a_w   <= w_iss_w;
          r_a_ph  <= w_iss_ph;
          r_ion   <= w_adv_on;
          r_iobj  <= w_adv_obj;
          r_iw    <= w_adv_w;
          r_iph   <= w_adv_ph;
          // a reject drops the data arriving for the abandoned object
          r_c_v    <= r_a_v && !w_reject;
          r_c_obj  <= r_a_obj;
          r_c_w    <= r_a_w;
          r_c_ph   <= r_a_ph;
          r_c_data <= bus.ext_data;
          if (r_c_v && r_bus8 && !r_c_ph) r_hi <= r_c_data[7:0];
          if (w_accept) begin
            r_acc  <= 1'b1;
            r_dest <= w_word[OBJW-1:0];
          end else if (w_reject) begin
            r_acc  <= 1'b0;
          end
          r_cnt <= w_cnt_nxt;
          if (w_last) r_obj_cnt <= w_cnt_nxt;
        end
        ST_DONE: begin
`ifdef JTOBJ_DBLBUF_EN
          r_bank <= ~r_bank;
`else
          r_bank <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    bus.scan_data <= r_mem[w_raddr];
  end

  assign bus.ext_addr = r_ext_addr;
  assign bus.obj_cnt  = r_obj_cnt;

endmodule
`default_nettype wire

// File: tb/tb_jtobj_dmascan.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtobj_dmascan
// Purpose  : Directed self-checking bench for jtobj_dmascan (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtobj_dmascan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b1;

  jtobj_dmascan_if #(.AW(13), .OBJW(8), .WPOW(3)) bus ();

  jtobj_dmascan #(.OBJW(8), .WPOW(3), .SKIPW(1), .AW(13)) dut (
    .rst (rst),
    .clk (clk),
    .cen (cen),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] ram16 [0:8191];
  logic [7:0]  ram8  [0:8191];

  // upper byte is garbage in 8-bit mode and must be ignored
  always_comb begin
    if (bus.bus8) bus.ext_data = {8'hA5, ram8[bus.ext_addr]};
    else          bus.ext_data = ram16[bus.ext_addr];
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          bsy_tot = 0;
  int          done_tot = 0;
  logic [12:0] last_addr = '0;
  logic [12:0] addr_log [$];

  always @(negedge clk) begin
    if (bus.dma_bsy) begin
      bsy_tot++;
      if (bus.ext_addr != last_addr) addr_log.push_back(bus.ext_addr);
      last_addr = bus.ext_addr;
    end else begin
      last_addr = '0;
    end
    if (bus.dma_done) done_tot++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_ram();
    for (int i = 0; i < 8192; i++) begin
      ram16[i] = '0;
      ram8[i]  = '0;
    end
  endtask

  task automatic scan(input int obj, input int w, output logic [15:0] d);
    bus.scan_addr = 11'(obj * 8 + w);
    tick();
    d = bus.scan_data;
  endtask

  // runs one DMA; mid>=0 pulses dma_start again after that many cycles
  task automatic run_dma(input logic b8, input int mid, output int bsy, output int dn);
    int b0, d0;
    b0 = bsy_tot;
    d0 = done_tot;
    bus.bus8      = b8;
    bus.dma_en    = 1'b1;
    bus.dma_start = 1'b1;
    tick();
    bus.dma_start = 1'b0;
    for (int k = 0; k < 6000 && bus.dma_bsy; k++) begin
      bus.dma_start = (k == mid);
      tick();
    end
    bus.dma_start = 1'b0;
    chk("dma_timeout", {31'd0, bus.dma_bsy}, 32'd0);
    repeat (3) tick();
    bsy = bsy_tot - b0;
    dn  = done_tot - d0;
  endtask

  task automatic load_a();
    clr_ram();
    ram16[0] = 16'h8005;
    for (int i = 1; i < 8; i++) ram16[i] = 16'(i * 16'h1111);
    ram16[8] = 16'h0003;
  endtask

  initial begin
    logic [15:0] d;
    int bsy, dn, lb, d0;
    bus.dma_en    = 1'b0;
    bus.bus8      = 1'b0;
    bus.dma_start = 1'b0;
    bus.scan_addr = '0;
    clr_ram();
    repeat (3) tick();
    chk("rst_ext_addr", {19'd0, bus.ext_addr}, 32'd0);
    chk("rst_bsy",      {31'd0, bus.dma_bsy},  32'd0);
    chk("rst_done",     {31'd0, bus.dma_done}, 32'd0);
    chk("rst_obj_cnt",  {23'd0, bus.obj_cnt},  32'd0);
    rst = 1'b0;
    tick();

    // start with dma_en low is ignored
    d0 = done_tot;
    bus.dma_start = 1'b1;
    tick();
    bus.dma_start = 1'b0;
    repeat (5) tick();
    chk("en0_bsy",  {31'd0, bus.dma_bsy}, 32'd0);
    chk("en0_done", 32'(done_tot - d0),   32'd0);

    // 16-bit basic copy: one accepted object (7 copy cens vs 2 for a reject)
    load_a();
    run_dma(1'b0, -1, bsy, dn);
    chk("a_bsy_len", 32'(bsy), 32'd2566);
    chk("a_done",    32'(dn),  32'd1);
    chk("a_obj_cnt", {23'd0, bus.obj_cnt}, 32'd1);
    for (int w = 0; w < 8; w++) begin
      scan(5, w, d);
      chk($sformatf("a_e5_w%0d", w), {16'd0, d}, (w == 7) ? 32'd0 : {16'd0, ram16[w]});
    end
    scan(3, 0, d);
    chk("a_e3_rejected", {16'd0, d}, 32'd0);

    // entry 5 seen during CLEAR of the next DMA
    ram16[1] = 16'hABCD;
    bus.dma_en = 1'b1;
    bus.dma_start = 1'b1;
    tick();
    bus.dma_start = 1'b0;
    repeat (100) tick();
    scan(5, 1, d);
`ifdef JTOBJ_DBLBUF_EN
    chk("e_during", {16'd0, d}, 32'h1111);
`else
    chk("e_during", {16'd0, d}, 32'h0000);
`endif
    for (int k = 0; k < 6000 && bus.dma_bsy; k++) tick();
    chk("e_timeout", {31'd0, bus.dma_bsy}, 32'd0);
    repeat (2) tick();
    scan(5, 1, d);
    chk("e_after", {16'd0, d}, 32'hABCD);

    // all objects rejected: 2048 clear + 1 fill + 2 per object
    clr_ram();
    run_dma(1'b0, -1, bsy, dn);
    chk("b_bsy_len", 32'(bsy), 32'd2561);
    chk("b_done",    32'(dn),  32'd1);
    chk("b_obj_cnt", {23'd0, bus.obj_cnt}, 32'd0);
    scan(5, 0, d);
    chk("b_e5_clear", {16'd0, d}, 32'd0);

    // 8-bit bus
    clr_ram();
    ram8[1] = 8'h80; ram8[0] = 8'h07; ram8[3] = 8'h12; ram8[2] = 8'h34;
    lb = addr_log.size();
    run_dma(1'b1, -1, bsy, dn);
    chk("c_obj_cnt", {23'd0, bus.obj_cnt}, 32'd1);
    scan(7, 0, d); chk("c_e7_w0", {16'd0, d}, 32'h8007);
    scan(7, 1, d); chk("c_e7_w1", {16'd0, d}, 32'h1234);
    scan(7, 2, d); chk("c_e7_w2", {16'd0, d}, 32'h0000);
    chk("c_log_len", {31'd0, addr_log.size() >= lb + 4}, 32'd1);
    if (addr_log.size() >= lb + 4) begin
      chk("c_addr0", {19'd0, addr_log[lb]},     32'd1);
      chk("c_addr1", {19'd0, addr_log[lb + 1]}, 32'd0);
      chk("c_addr2", {19'd0, addr_log[lb + 2]}, 32'd3);
      chk("c_addr3", {19'd0, addr_log[lb + 3]}, 32'd2);
    end

    // priority collision: later object wins
    clr_ram();
    ram16[16] = 16'h8004; ram16[17] = 16'hAAAA; ram16[18] = 16'h5555;
    ram16[72] = 16'h8104; ram16[73] = 16'hBBBB;
    run_dma(1'b0, -1, bsy, dn);
    chk("d_obj_cnt", {23'd0, bus.obj_cnt}, 32'd2);
    scan(4, 0, d); chk("d_e4_w0", {16'd0, d}, 32'h8104);
    scan(4, 1, d); chk("d_e4_w1", {16'd0, d}, 32'hBBBB);
    scan(4, 2, d); chk("d_e4_w2", {16'd0, d}, 32'h0000);

    // dma_start mid-COPY is ignored
    load_a();
    run_dma(1'b0, 2100, bsy, dn);
    chk("f_mid_bsy_len", 32'(bsy), 32'd2566);
    chk("f_mid_done",    32'(dn),  32'd1);

    // reset mid-COPY aborts without a done pulse
    d0 = done_tot;
    bus.dma_start = 1'b1;
    tick();
    bus.dma_start = 1'b0;
    repeat (2100) tick();
    rst = 1'b1;
    #1;
    chk("g_rst_bsy", {31'd0, bus.dma_bsy}, 32'd0);
    repeat (5) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("g_rst_done",    32'(done_tot - d0), 32'd0);
    chk("g_rst_obj_cnt", {23'd0, bus.obj_cnt}, 32'd0);
    run_dma(1'b0, -1, bsy, dn);
    chk("g_new_bsy_len", 32'(bsy), 32'd2566);
    chk("g_new_done",    32'(dn),  32'd1);
    chk("g_new_obj_cnt", {23'd0, bus.obj_cnt}, 32'd1);
    scan(5, 0, d);
    chk("g_new_e5_w0", {16'd0, d}, 32'h8005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
